// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Timer width covers the largest phase length plus one guard bit.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_SETTLE,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } seq_state_t;

   function automatic int tmr_width(input int hold_c, input int settle_c, input int timeout_c);
      int m;
      m = hold_c;
      if (settle_c > m) m = settle_c;
      if (timeout_c > m) m = timeout_c;
      return $clog2(m) + 1;
   endfunction

   localparam int DEF_TMR_W = tmr_width(4, 2, 100);

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter shared by the HOLD, SETTLE and RUN phases.
// Load wins over decrement; the count parks at zero.
module seq_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer and run supervisor: hold, settle, run under watchdog, report pass/timeout.
// All outputs registered; software re-reset via level request with a one-cycle ack.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int HOLD_CYCLES    = 4,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 100,
   parameter int CNT_W          = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_sw_rst_req,
   input  logic             i_dut_done,
   output logic             o_reset_l,
   output logic             o_running,
   output logic             o_sw_rst_ack,
   output logic             o_pass,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_reset_count
);

   localparam int TMR_W = tmr_width(HOLD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] HOLD_LD    = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);

   seq_state_t       r_state;
   seq_state_t       w_next;
   logic             w_accept;
   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_val;
   logic             w_tmr_dec;
   logic             w_tmr_zero;
   logic             r_reset_l;
   logic             r_running;
   logic             r_ack;
   logic             r_pass;
   logic             r_timeout;
   logic [CNT_W-1:0] r_count;

   seq_timer #(.W(TMR_W)) u_timer (
      .i_clk      (i_clk),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_zero     (w_tmr_zero)
   );

   // In RUN, completion outranks a re-reset request, which outranks the watchdog.
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      w_tmr_dec  = 1'b0;
      if (i_reset) begin
         w_next     = ST_HOLD;
         w_tmr_load = 1'b1;
         w_tmr_val  = HOLD_LD;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (w_tmr_zero) begin
                  w_next     = ST_SETTLE;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = SETTLE_LD;
               end else begin
                  w_tmr_dec = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (w_tmr_zero) begin
                  w_next     = ST_RUN;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = TIMEOUT_LD;
               end else begin
                  w_tmr_dec = 1'b1;
               end
            end
            ST_RUN: begin
               if (i_dut_done) begin
                  w_next = ST_DONE;
               end else if (i_sw_rst_req) begin
                  w_next     = ST_HOLD;
                  w_accept   = 1'b1;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = HOLD_LD;
               end else if (w_tmr_zero) begin
                  w_next = ST_TIMEOUT;
               end else begin
                  w_tmr_dec = 1'b1;
               end
            end
            ST_DONE, ST_TIMEOUT: begin
               if (i_sw_rst_req) begin
                  w_next     = ST_HOLD;
                  w_accept   = 1'b1;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = HOLD_LD;
               end
            end
            default: begin
               w_next     = ST_HOLD;
               w_tmr_load = 1'b1;
               w_tmr_val  = HOLD_LD;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_HOLD;
         r_reset_l <= 1'b0;
         r_running <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
         r_ack     <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state   <= w_next;
         r_reset_l <= (w_next != ST_HOLD);
         r_running <= (w_next == ST_RUN);
         r_pass    <= (w_next == ST_DONE);
         r_timeout <= (w_next == ST_TIMEOUT);
         r_ack     <= w_accept;
         if (w_accept && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_reset_l     = r_reset_l;
   assign o_running     = r_running;
   assign o_sw_rst_ack  = r_ack;
   assign o_pass        = r_pass;
   assign o_timeout     = r_timeout;
   assign o_reset_count = r_count;

   a_reset_l_hold: assert property (@(posedge i_clk) disable iff (i_reset)
      o_reset_l == (r_state != ST_HOLD));
   a_status_mutex: assert property (@(posedge i_clk) disable iff (i_reset)
      $onehot0({o_running, o_pass, o_timeout}));
   c_ack_pulse: cover property (@(posedge i_clk) o_sw_rst_ack);
   c_timeout_entry: cover property (@(posedge i_clk) !o_timeout ##1 o_timeout);

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus pushes cycle-stamped expectations, a negedge monitor checks them.
// A second instance with a 2-bit counter covers saturation.
module tb_reset_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       done = 1'b0;
   logic       reset_l, running, ack, pass, timeout;
   logic [7:0] count;
   logic       reset_l2, running2, ack2, pass2, timeout2;
   logic [1:0] count2;

   reset_seq dut (
      .i_clk(clk), .i_reset(reset), .i_sw_rst_req(req), .i_dut_done(done),
      .o_reset_l(reset_l), .o_running(running), .o_sw_rst_ack(ack),
      .o_pass(pass), .o_timeout(timeout), .o_reset_count(count)
   );

   reset_seq #(.CNT_W(2)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_sw_rst_req(req), .i_dut_done(done),
      .o_reset_l(reset_l2), .o_running(running2), .o_sw_rst_ack(ack2),
      .o_pass(pass2), .o_timeout(timeout2), .o_reset_count(count2)
   );

   always #5 clk = ~clk;

   localparam int S_RSTL = 0, S_RUN = 1, S_ACK = 2, S_PASS = 3, S_TMO = 4, S_CNT = 5, S_CNT2 = 6;

   typedef struct {
      int scen;
      int cyc;
      int sig;
      int val;
   } exp_t;

   exp_t  exp_q[$];
   int    cyc_abs = 0;
   int    base = 0;
   bit    armed = 1'b0;
   int    scen = 0;
   int    n_cmp = 0;
   int    n_bad = 0;

   always @(posedge clk) cyc_abs <= cyc_abs + 1;

   function automatic string sig_name(input int s);
      case (s)
         S_RSTL:  return "reset_l";
         S_RUN:   return "running";
         S_ACK:   return "sw_rst_ack";
         S_PASS:  return "pass";
         S_TMO:   return "timeout";
         S_CNT:   return "reset_count";
         default: return "reset_count(CNT_W=2)";
      endcase
   endfunction

   function automatic int get_sig(input int s);
      case (s)
         S_RSTL:  return int'(reset_l);
         S_RUN:   return int'(running);
         S_ACK:   return int'(ack);
         S_PASS:  return int'(pass);
         S_TMO:   return int'(timeout);
         S_CNT:   return int'(count);
         default: return int'(count2);
      endcase
   endfunction

   task automatic expect_at(input int c, input int s, input int v);
      exp_t e;
      e.scen = scen;
      e.cyc  = c;
      e.sig  = s;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      int rel;
      int act;
      if (armed) begin
         rel = cyc_abs - base;
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == rel) begin
               act = get_sig(exp_q[i].sig);
               n_cmp++;
               if (act != exp_q[i].val) begin
                  n_bad++;
                  $display("FAIL s%0d.%s cycle %0d: actual %0d required %0d",
                           exp_q[i].scen, sig_name(exp_q[i].sig), rel, act, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
      end
   end

   // Leaves the caller 2 time units after the rising edge that starts relative cycle k.
   task automatic at_cyc(input int k);
      int guard;
      guard = 0;
      while (((cyc_abs - base) < k) && (guard < 5000)) begin
         @(posedge clk);
         #2;
         guard++;
      end
      if (guard >= 5000) begin
         n_bad++;
         $display("FAIL s%0d.wait cycle budget expired before cycle %0d", scen, k);
      end
   endtask

   task automatic start_scen(input int id);
      @(posedge clk);
      #2;
      scen  = id;
      reset = 1'b1;
      req   = 1'b0;
      done  = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      base  = cyc_abs;
      armed = 1'b1;
   endtask

   task automatic end_scen(input int last);
      at_cyc(last + 1);
      while (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL s%0d.%s cycle %0d: never checked, required %0d",
                  exp_q[0].scen, sig_name(exp_q[0].sig), exp_q[0].cyc, exp_q[0].val);
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      // Power-up, completion at cycle 20.
      start_scen(1);
      expect_at(0, S_RSTL, 0); expect_at(0, S_RUN, 0); expect_at(0, S_PASS, 0);
      expect_at(0, S_TMO, 0);  expect_at(0, S_ACK, 0); expect_at(0, S_CNT, 0);
      expect_at(3, S_RSTL, 0); expect_at(4, S_RSTL, 1);
      expect_at(5, S_RUN, 0);  expect_at(6, S_RUN, 1);
      at_cyc(20);
      done = 1'b1;
      expect_at(20, S_RUN, 1); expect_at(20, S_PASS, 0);
      expect_at(21, S_RUN, 0); expect_at(21, S_PASS, 1); expect_at(25, S_PASS, 1);
      at_cyc(21);
      done = 1'b0;
      end_scen(25);

      // Watchdog expiry.
      start_scen(2);
      expect_at(6, S_RUN, 1);   expect_at(105, S_RUN, 1); expect_at(105, S_TMO, 0);
      expect_at(106, S_TMO, 1); expect_at(106, S_RUN, 0); expect_at(106, S_PASS, 0);
      expect_at(110, S_TMO, 1); expect_at(110, S_PASS, 0);
      end_scen(110);

      // One-cycle re-reset request in RUN.
      start_scen(3);
      at_cyc(10);
      req = 1'b1;
      expect_at(10, S_ACK, 0);  expect_at(11, S_ACK, 1);  expect_at(12, S_ACK, 0);
      expect_at(10, S_RSTL, 1); expect_at(11, S_RSTL, 0); expect_at(14, S_RSTL, 0);
      expect_at(15, S_RSTL, 1); expect_at(11, S_CNT, 1);  expect_at(11, S_CNT2, 1);
      expect_at(16, S_RUN, 0);  expect_at(17, S_RUN, 1);
      at_cyc(11);
      req = 1'b0;
      end_scen(18);

      // Completion and request together: done wins, request taken from DONE.
      start_scen(4);
      at_cyc(20);
      done = 1'b1;
      req  = 1'b1;
      expect_at(21, S_PASS, 1); expect_at(21, S_ACK, 0); expect_at(21, S_CNT, 0);
      at_cyc(21);
      done = 1'b0;
      expect_at(22, S_ACK, 1);  expect_at(22, S_PASS, 0); expect_at(22, S_RSTL, 0);
      expect_at(22, S_CNT, 1);  expect_at(23, S_ACK, 0);
      at_cyc(22);
      req = 1'b0;
      end_scen(23);

      // Mid-run reset overrides a simultaneous request and clears the count.
      start_scen(5);
      at_cyc(10);
      req = 1'b1;
      at_cyc(11);
      req = 1'b0;
      expect_at(30, S_CNT, 1);  expect_at(30, S_RUN, 1);
      at_cyc(30);
      reset = 1'b1;
      req   = 1'b1;
      expect_at(31, S_RSTL, 0); expect_at(31, S_RUN, 0); expect_at(31, S_CNT, 0);
      expect_at(31, S_ACK, 0);
      at_cyc(31);
      reset = 1'b0;
      req   = 1'b0;
      expect_at(34, S_RSTL, 0); expect_at(35, S_RSTL, 1); expect_at(37, S_RUN, 1);
      end_scen(37);

      // Five accepted requests: 2-bit count saturates, 8-bit count keeps going.
      start_scen(6);
      for (int i = 0; i < 5; i++) begin
         at_cyc(6 + 7 * i);
         req = 1'b1;
         expect_at(7 + 7 * i, S_ACK, 1);
         expect_at(7 + 7 * i, S_CNT, i + 1);
         expect_at(7 + 7 * i, S_CNT2, (i < 3) ? i + 1 : 3);
         at_cyc(7 + 7 * i);
         req = 1'b0;
      end
      end_scen(42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/reset_seq.md
# reset_seq

Simulation-side reset sequencer and run supervisor for the demo test top. It drives the active-low `reset_l` consumed by the counter/test sub-blocks, holds it for a programmable number of cycles, and waits a settle period before declaring the run active. It then watches a `dut_done` indication from the sub-block under a watchdog and reports pass or timeout. It also accepts software-style re-reset requests through a req/ack handshake and counts them.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: cycles `reset_l` is held low after reset release or a re-reset request. Must be ≥1.
- `SETTLE_CYCLES`, 2: cycles between `reset_l` rising and `running` asserting. Must be ≥1.
- `TIMEOUT_CYCLES`, 100: maximum RUN cycles allowed before `timeout`. Must be ≥1.
- `CNT_W`, 8: width of `reset_count`.

Ports:
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high reset. Polarity and synchronicity are fixed.
- `sw_rst_req` in 1: level re-reset request. Sampled only in RUN, DONE and TIMEOUT.
- `dut_done` in 1: downstream completion flag. Sampled only in RUN.
- `reset_l` out 1: active-low reset to downstream.
- `running` out 1: high in RUN.
- `sw_rst_ack` out 1: one-cycle pulse, high in the first HOLD cycle after an accepted request.
- `pass` out 1: high in DONE.
- `timeout` out 1: high in TIMEOUT.
- `reset_count` out CNT_W: number of accepted re-reset requests. Saturates at all-ones.

## Operation
- States are HOLD, SETTLE, RUN, DONE and TIMEOUT. All outputs are registered or decoded directly from the state register, so there are no combinational input-to-output paths.
- Output decode:
  - `reset_l` = (state != HOLD)
  - `running` = RUN
  - `pass` = DONE
  - `timeout` = TIMEOUT
- While `reset` is high:
  - state is HOLD and the timer is loaded with HOLD_CYCLES-1.
  - `reset_count` = 0 and `sw_rst_ack` = 0.
  - Resulting outputs: `reset_l` = 0; `running`, `pass` and `timeout` = 0.
- HOLD: the timer decrements each cycle. When the timer reaches 0, the next state is SETTLE and the timer is loaded with SETTLE_CYCLES-1. Inputs are ignored.
- SETTLE: the same countdown applies. On expiry the next state is RUN and the timer is loaded with TIMEOUT_CYCLES-1. Inputs are ignored.
- RUN transitions, in priority order:
  1. `dut_done` → DONE.
  2. `sw_rst_req` → HOLD; assert `sw_rst_ack`; increment `reset_count`.
  3. Timer = 0 → TIMEOUT.
  4. Otherwise, decrement the timer.
- DONE and TIMEOUT are terminal except that `sw_rst_req` → HOLD with ack and count increment. Entering HOLD clears `pass` and `timeout`.
- Every entry to HOLD reloads the timer with HOLD_CYCLES-1.
- `reset_count` saturates and never wraps.
- Timer width is $clog2 of the largest parameter value, +1.

## Timing
- Cycle 0 is the first cycle in which `reset` is sampled low.
- Power-up sequence:
  - `reset_l` = 0 in cycles 0..HOLD_CYCLES-1 and rises in cycle HOLD_CYCLES.
  - `running` rises in cycle HOLD_CYCLES+SETTLE_CYCLES.
- `dut_done` sampled high in RUN cycle k: `running` = 0 and `pass` = 1 in cycle k+1.
- No `dut_done` seen: RUN lasts exactly TIMEOUT_CYCLES cycles, and `timeout` = 1 in the following cycle.
- `sw_rst_req` accepted in cycle k:
  - `sw_rst_ack` = 1 in cycle k+1 only.
  - `reset_l` = 0 in cycles k+1..k+HOLD_CYCLES.
  - `running` returns in cycle k+1+HOLD_CYCLES+SETTLE_CYCLES.
  - `reset_count` updates in cycle k+1.
- Simultaneous events:
  - `dut_done` and `sw_rst_req` together in RUN: `dut_done` wins and there is no ack. The request, if still held, is accepted in DONE on the next cycle.
  - `dut_done` in the last RUN cycle (timer = 0): pass, not timeout.
- A request held high in HOLD or SETTLE is ignored. It is not queued; if still high in RUN, it is accepted.
- `reset` asserted in any state takes effect on the next edge and overrides everything, including a pending ack.

## Structure
- `reset_seq_pkg` holds:
  - the `seq_state_t` enum (HOLD, SETTLE, RUN, DONE, TIMEOUT);
  - the localparam computing the timer width.
- One sub-module, `seq_timer`: a loadable down-counter with inputs `load`, `load_val` and `dec`, and output `zero`. It is shared by the HOLD, SETTLE and RUN phases.
- Embedded checks:
  - Assertion: `reset_l` is low iff the state is HOLD.
  - Assertion: `running`, `pass` and `timeout` are mutually exclusive.
  - Cover: `sw_rst_ack` pulse.
  - Cover: TIMEOUT entry.

## Test plan
All scenarios use default parameters unless noted.
- Release `reset` at cycle 0; pulse `dut_done` in cycle 20.
  - Required: `reset_l` rises in cycle 4, `running` in cycle 6.
  - Required: `pass` = 1 and `running` = 0 from cycle 21.
- Release `reset` and never assert `dut_done`.
  - Required: `running` in cycles 6..105; `timeout` = 1 from cycle 106; `pass` stays 0.
- Raise `sw_rst_req` in cycle 10 for one cycle.
  - Required: `sw_rst_ack` high in cycle 11 only; `reset_l` low in cycles 11–14.
  - Required: `reset_count` = 1; `running` again in cycle 17.
- Assert `dut_done` and `sw_rst_req` in cycle 20, holding the request through cycle 21.
  - Required: `pass` = 1 in cycle 21 with no ack.
  - Required: ack in cycle 22, `pass` = 0 in cycle 22, `reset_count` = 1.
- Assert `reset` for one cycle in cycle 30 during RUN.
  - Required: cycle 31 has `reset_l` = 0, `running` = 0, `reset_count` = 0.
  - Required: the sequence restarts with `reset_l` rising in cycle 35.
- With CNT_W = 2, issue 5 accepted requests.
  - Required: `reset_count` reads 1, 2, 3, 3, 3.
